// File: rtl/nn_inference_sequencer.sv
// Forward-pass sequencer for the output layer: clears and steps the MAC over every
// pixel for each class, keeps the best signed score and reports the winning class.
module nn_inference_sequencer #(
    parameter int NUM_PIXELS  = 196,
    parameter int NUM_CLASSES = 10,
    parameter int ACC_W       = 16,
    parameter int MAC_LAT     = 1
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      image_ready,
    input  logic signed [ACC_W-1:0]                   acc_in,
    output logic                                      acc_clr,
    output logic                                      mac_en,
    output logic [$clog2(NUM_PIXELS)-1:0]             pix_addr,
    output logic [$clog2(NUM_CLASSES*NUM_PIXELS)-1:0] wt_addr,
    output logic                                      busy,
    output logic                                      done,
    output logic [3:0]                                class_out
);

    localparam int PIX_W = $clog2(NUM_PIXELS);
    localparam int WT_W  = $clog2(NUM_CLASSES * NUM_PIXELS);
    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int DRN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_CMP,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [PIX_W-1:0]         r_pix;
    logic [WT_W-1:0]          r_wt;
    logic [CLS_W-1:0]         r_class;
    logic [CLS_W-1:0]         r_best_class;
    logic [DRN_W-1:0]         r_drain;
    logic signed [ACC_W-1:0]  r_best;

    logic                     w_take;
    logic [CLS_W-1:0]         w_winner;

    // Class 0 always seeds the best score; strict compare keeps ties on the lower class.
    always_comb begin
        w_take   = (r_class == '0) || (acc_in > r_best);
        w_winner = w_take ? r_class : r_best_class;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_pix        <= '0;
            r_wt         <= '0;
            r_class      <= '0;
            r_best_class <= '0;
            r_drain      <= '0;
            r_best       <= '0;
            acc_clr      <= 1'b0;
            mac_en       <= 1'b0;
            pix_addr     <= '0;
            wt_addr      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            class_out    <= '0;
        end else begin
            // NOTE: pulse outputs and addresses default low here, so every state only
            // raises what it needs and nothing can hold over a stale value.
            acc_clr  <= 1'b0;
            mac_en   <= 1'b0;
            pix_addr <= '0;
            wt_addr  <= '0;

            if ((r_state inside {S_CLR, S_MAC, S_DRAIN, S_CMP}) && !image_ready) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (image_ready) begin
                            r_state <= S_CLR;
                            r_class <= '0;
                            r_wt    <= '0;
                            acc_clr <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                    S_CLR: begin
                        r_state  <= S_MAC;
                        r_pix    <= '0;
                        mac_en   <= 1'b1;
                        pix_addr <= '0;
                        wt_addr  <= r_wt;
                    end
                    S_MAC: begin
                        // r_wt runs continuously, so it equals class*NUM_PIXELS + pix.
                        r_wt <= r_wt + 1'b1;
                        if (r_pix == PIX_LAST) begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end else begin
                            r_pix    <= r_pix + 1'b1;
                            mac_en   <= 1'b1;
                            pix_addr <= r_pix + 1'b1;
                            wt_addr  <= r_wt + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        r_drain <= r_drain + 1'b1;
                        if (r_drain == DRN_LAST) begin
                            r_state <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        if (w_take) begin
                            r_best       <= acc_in;
                            r_best_class <= r_class;
                        end
                        if (r_class == CLS_LAST) begin
                            r_state   <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            class_out <= 4'(w_winner);
                        end else begin
                            r_state <= S_CLR;
                            r_class <= r_class + 1'b1;
                            acc_clr <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        if (!image_ready) begin
                            r_state <= S_IDLE;
                            done    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: a behavioural MAC datapath returns per-class scores
// and an argmax model predicts the winner, latency and MAC/clear activity.
module tb_nn_inference_sequencer;

    localparam int NP   = 196;
    localparam int NC   = 10;
    localparam int AW   = 16;
    localparam int LAT  = 1;
    localparam int EXP_LATENCY = 1 + NC * (NP + LAT + 2);

    logic                          clk;
    logic                          reset_n;
    logic                          image_ready;
    logic signed [AW-1:0]          acc_in;
    logic                          acc_clr;
    logic                          mac_en;
    logic [$clog2(NP)-1:0]         pix_addr;
    logic [$clog2(NC*NP)-1:0]      wt_addr;
    logic                          busy;
    logic                          done;
    logic [3:0]                    class_out;

    nn_inference_sequencer #(
        .NUM_PIXELS (NP),
        .NUM_CLASSES(NC),
        .ACC_W      (AW),
        .MAC_LAT    (LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .image_ready(image_ready),
        .acc_in     (acc_in),
        .acc_clr    (acc_clr),
        .mac_en     (mac_en),
        .pix_addr   (pix_addr),
        .wt_addr    (wt_addr),
        .busy       (busy),
        .done       (done),
        .class_out  (class_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int scores[NC];
    int prev_winner;

    // Monitor counters, cleared by the stimulus thread before each run.
    int clr_cnt, mac_cnt, exp_wt, addr_err, busy_err;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Datapath model: random partial sums during the sweep, final score after last pixel.
    always @(posedge clk) begin
        if (!reset_n || acc_clr) begin
            acc_in <= '0;
        end else if (mac_en) begin
            if (int'(pix_addr) == NP - 1)
                acc_in <= AW'(scores[int'(wt_addr) / NP]);
            else
                acc_in <= acc_in + AW'($urandom_range(0, 7));
        end
    end

    always @(negedge clk) begin
        if (acc_clr) clr_cnt++;
        if (mac_en) begin
            mac_cnt++;
            if (int'(wt_addr) != exp_wt || int'(pix_addr) != exp_wt % NP) addr_err++;
            exp_wt++;
        end else if (pix_addr != 0 || wt_addr != 0) begin
            addr_err++;
        end
    end

    function automatic int ref_winner();
        int best = 0;
        for (int k = 1; k < NC; k++)
            if (scores[k] > scores[best]) best = k;
        return best;
    endfunction

    task automatic clear_counters();
        clr_cnt  = 0;
        mac_cnt  = 0;
        exp_wt   = 0;
        addr_err = 0;
        busy_err = 0;
    endtask

    // Called at a negedge; the next posedge samples image_ready high.
    task automatic start_run();
        clear_counters();
        image_ready = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        int exp_cls = ref_winner();
        while (1) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done || cyc > 5000) break;
            if (!busy) busy_err++;
        end
        check({tag, "_latency"}, cyc, EXP_LATENCY);
        check({tag, "_class"}, class_out, exp_cls);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_busy_run"}, busy_err, 0);
        check({tag, "_clr_cnt"}, clr_cnt, NC);
        check({tag, "_mac_cnt"}, mac_cnt, NC * NP);
        check({tag, "_addr"}, addr_err, 0);
        prev_winner = exp_cls;
    endtask

    task automatic drop_ready(input string tag);
        image_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_class_hold"}, class_out, prev_winner);
    endtask

    task automatic random_scores(input bit force_tie);
        for (int k = 0; k < NC; k++)
            scores[k] = int'($urandom_range(0, 65535)) - 32768;
        if (force_tie) scores[$urandom_range(5, 9)] = scores[ref_winner()];
    endtask

    task automatic wait_wt(input int target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (mac_en && int'(wt_addr) == target) found = 1'b1;
        end
    endtask

    initial begin
        bit found;
        int hold_err;

        reset_n     = 1'b0;
        image_ready = 1'b0;
        prev_winner = 0;
        for (int k = 0; k < NC; k++) scores[k] = 0;
        clear_counters();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_acc_clr", acc_clr, 0);
        check("rst_mac_en", mac_en, 0);
        check("rst_pix", pix_addr, 0);
        check("rst_wt", wt_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_class", class_out, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", clr_cnt, 0);

        // All-zero scores: tie rule selects class 0.
        start_run();
        wait_done("zeros");
        drop_ready("zeros");

        for (int k = 0; k < NC; k++) scores[k] = 10 * k - 50;
        scores[7] = 900;
        start_run();
        wait_done("peak7");
        drop_ready("peak7");

        for (int k = 0; k < NC; k++) scores[k] = -int'($urandom_range(20, 300));
        scores[4] = -5;
        start_run();
        wait_done("neg4");

        // Held-high image_ready after done must not retrigger.
        clear_counters();
        hold_err = 0;
        repeat (3000) begin
            @(negedge clk);
            if (!done || busy) hold_err++;
        end
        check("hold_state", hold_err, 0);
        check("hold_no_clr", clr_cnt, 0);
        check("hold_class", class_out, prev_winner);
        drop_ready("hold");
        random_scores(1'b0);
        start_run();
        wait_done("rerun");
        drop_ready("rerun");

        for (int r = 0; r < 4; r++) begin
            random_scores(r[0]);
            start_run();
            wait_done($sformatf("rand%0d", r));
            drop_ready($sformatf("rand%0d", r));
        end

        // Abort during class 3, pixel 100.
        random_scores(1'b0);
        start_run();
        wait_wt(3 * NP + 100, found);
        check("abort_found", found, 1);
        image_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_mac_en", mac_en, 0);
        check("abort_acc_clr", acc_clr, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_class", class_out, prev_winner);
        check("abort_addr", wt_addr, 0);
        repeat (5) @(negedge clk);
        check("abort_idle", busy, 0);

        // Reset asserted in the compare cycle of class 2.
        random_scores(1'b0);
        start_run();
        wait_wt(2 * NP + NP - 1, found);
        check("rstcmp_found", found, 1);
        @(negedge clk);
        @(negedge clk);
        check("rstcmp_busy_before", busy, 1);
        reset_n     = 1'b0;
        image_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstcmp_busy", busy, 0);
        check("rstcmp_mac_en", mac_en, 0);
        check("rstcmp_acc_clr", acc_clr, 0);
        check("rstcmp_done", done, 0);
        check("rstcmp_class", class_out, 0);
        reset_n = 1'b1;
        prev_winner = 0;
        @(negedge clk);
        random_scores(1'b1);
        start_run();
        wait_done("post_rst");
        drop_ready("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
